// File: rtl/tim_so.sv
// tim_so: successive-approximation search driving a magnitude comparator's b input.
// Define TIM_SO_SETTLE_EN to insert a SETTLE cycle before every compare (registered comparator).
module tim_so #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         x,
  input  logic         y,
  input  logic         z,
  output logic [W-1:0] guess,
  output logic         busy,
  output logic         done,
  output logic         err,
  output logic [W-1:0] result,
  output logic [W-1:0] tries
);
`ifdef TIM_SO_SETTLE_EN
  typedef enum logic [2:0] {IDLE, CMP, DONE, ERR, SETTLE} state_t;
  localparam state_t LOAD = SETTLE;
`else
  typedef enum logic [1:0] {IDLE, CMP, DONE, ERR} state_t;
  localparam state_t LOAD = CMP;
`endif
  state_t state, state_n;
  logic [W:0] lo, hi, lo_n, hi_n;
  logic [W+1:0] sum;
  logic [W-1:0] guess_n, result_n, tries_n;
  logic done_n, err_n, one_hot, empty;
  assign busy = (state != IDLE) && (state != DONE) && (state != ERR);
  assign one_hot = (x ^ y ^ z) && !(x && y && z);
  always_comb begin
    state_n = state;
    lo_n = lo;
    hi_n = hi;
    guess_n = guess;
    result_n = result;
    tries_n = tries;
    done_n = done;
    err_n = err;
    sum = '0;
    empty = 1'b0;
    case (state)
      IDLE, DONE, ERR: begin
        if (start) begin
          state_n = LOAD;
          lo_n = '0;
          hi_n = {1'b0, {W{1'b1}}};
          guess_n = {1'b0, {(W-1){1'b1}}};
          tries_n = '0;
          result_n = '0;
          done_n = 1'b0;
          err_n = 1'b0;
        end
      end
      CMP: begin
        tries_n = tries + 1'b1;
        if (!one_hot) begin
          state_n = ERR;
          err_n = 1'b1;
        end else if (z) begin
          state_n = DONE;
          result_n = guess;
          done_n = 1'b1;
        end else begin
          lo_n = x ? {1'b0, guess} + 1'b1 : lo;
          hi_n = y ? {1'b0, guess} - 1'b1 : hi;
          // guess-1 underflows to all ones at guess=0, so flag that range empty explicitly
          empty = (y && guess == '0) || (lo_n > hi_n);
          sum = {1'b0, lo_n} + {1'b0, hi_n};
          state_n = empty ? ERR : LOAD;
          err_n = empty;
          guess_n = empty ? guess : W'(sum >> 1);
        end
      end
      default: state_n = CMP;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      lo <= '0;
      hi <= '0;
      guess <= '0;
      result <= '0;
      tries <= '0;
      done <= 1'b0;
      err <= 1'b0;
    end else begin
      state <= state_n;
      lo <= lo_n;
      hi <= hi_n;
      guess <= guess_n;
      result <= result_n;
      tries <= tries_n;
      done <= done_n;
      err <= err_n;
    end
  end
endmodule

// File: tb/tb_tim_so.sv
// tb_tim_so: scoreboard bench; stimulus queues expected guesses/end records, monitor pops and compares.
module tb_tim_so;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic x, y, z;
  logic [3:0] guess, result, tries, target = '0;
  logic busy, done, err;
  int mode = 0;
  int total = 0, passed = 0;
  int exp_guess[$];
  int exp_end[$];
  logic ended = 1'b0;
  tim_so #(.W(4)) dut (
    .clk(clk), .rst(rst), .start(start), .x(x), .y(y), .z(z),
    .guess(guess), .busy(busy), .done(done), .err(err), .result(result), .tries(tries)
  );
  always #5 clk = ~clk;
  // mode 0 ideal comparator, 1 x stuck high, 2 all flags low, 3 y stuck high
  assign x = (mode == 0) ? target > guess : (mode == 1);
  assign y = (mode == 0) ? target < guess : (mode == 3);
  assign z = (mode == 0) ? target == guess : 1'b0;
  task automatic check(input string nm, input int got, input int want);
    total++;
    if (got == want) passed++;
    else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, got, got, want, want);
  endtask
  always @(negedge clk) begin
    if (rst) ended = 1'b0;
    else begin
      if (busy) begin
        if (exp_guess.size() == 0) check("unexpected_guess", int'(guess), -1);
        else check("guess", int'(guess), exp_guess.pop_front());
      end
      if ((done || err) && !ended) begin
        if (exp_end.size() == 0) check("unexpected_end", int'({done, err, result, tries}), -1);
        else check("end{done,err,result,tries}", int'({done, err, result, tries}), exp_end.pop_front());
      end
      ended = done || err;
    end
  end
  task automatic search(input logic [3:0] ta, input int md, input int n, input logic [19:0] gs,
                        input logic e_done, input logic e_err, input logic [3:0] e_res, input bit poke);
    for (int i = 0; i < n; i++) exp_guess.push_back(int'(gs[4*i +: 4]));
    exp_end.push_back(int'({e_done, e_err, e_res, 4'(n)}));
    target = ta;
    mode = md;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    if (poke) begin
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
    end
    for (int c = 0; c < 20 && !(done || err); c++) @(negedge clk);
    if (!(done || err)) check("timeout", 0, 1);
    repeat (2) @(negedge clk);
  endtask
  initial begin
    repeat (2) @(negedge clk);
    check("reset_outputs", int'({guess, busy, done, err, result, tries}), 0);
    rst = 1'b0;
    @(negedge clk);
    search(4'd9, 0, 3, 20'({4'd9, 4'd11, 4'd7}), 1'b1, 1'b0, 4'd9, 1'b0);
    search(4'd15, 0, 5, {4'd15, 4'd14, 4'd13, 4'd11, 4'd7}, 1'b1, 1'b0, 4'd15, 1'b0);
    search(4'd0, 0, 4, 20'({4'd0, 4'd1, 4'd3, 4'd7}), 1'b1, 1'b0, 4'd0, 1'b0);
    search(4'd0, 1, 5, {4'd15, 4'd14, 4'd13, 4'd11, 4'd7}, 1'b0, 1'b1, 4'd0, 1'b0);
    check("guess_held_in_err", int'(guess), 15);
    search(4'd0, 2, 1, 20'd7, 1'b0, 1'b1, 4'd0, 1'b0);
    search(4'd0, 3, 4, 20'({4'd0, 4'd1, 4'd3, 4'd7}), 1'b0, 1'b1, 4'd0, 1'b0);
    search(4'd12, 0, 4, 20'({4'd12, 4'd13, 4'd11, 4'd7}), 1'b1, 1'b0, 4'd12, 1'b1);
    target = 4'd9;
    mode = 0;
    exp_guess.push_back(7);
    exp_guess.push_back(11);
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    @(negedge clk) rst = 1'b1;
    @(negedge clk);
    check("mid_reset_outputs", int'({guess, busy, done, err, result, tries}), 0);
    rst = 1'b0;
    exp_guess.delete();
    exp_end.delete();
    search(4'd9, 0, 3, 20'({4'd9, 4'd11, 4'd7}), 1'b1, 1'b0, 4'd9, 1'b0);
    check("leftover_expectations", exp_guess.size() + exp_end.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
